// File: rtl/gpr_wb_scheduler_if.sv
// Bundle between issue/decode, the two writeback requesters and the
// register-file write port. The scheduler takes the slave view.
interface gpr_wb_scheduler_if #(
   parameter int XLEN = 32,
   parameter int RAW  = 5
);
   logic            issue_valid;
   logic [RAW-1:0]  issue_rd;
   logic            issue_ready;
   logic [RAW-1:0]  rs1;
   logic [RAW-1:0]  rs2;
   logic            busy1;
   logic            busy2;
   logic            wb0_valid;
   logic [RAW-1:0]  wb0_addr;
   logic [XLEN-1:0] wb0_data;
   logic            wb0_ready;
   logic            wb1_valid;
   logic [RAW-1:0]  wb1_addr;
   logic [XLEN-1:0] wb1_data;
   logic            wb1_ready;
   logic            gpr_wena;
   logic [RAW-1:0]  gpr_waddr;
   logic [XLEN-1:0] gpr_wdata;
   logic [RAW:0]    pending_cnt;
   logic            err;

   modport master (
      output issue_valid, issue_rd, rs1, rs2,
             wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
      input  issue_ready, busy1, busy2, wb0_ready, wb1_ready,
             gpr_wena, gpr_waddr, gpr_wdata, pending_cnt, err
   );

   modport slave (
      input  issue_valid, issue_rd, rs1, rs2,
             wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
      output issue_ready, busy1, busy2, wb0_ready, wb1_ready,
             gpr_wena, gpr_waddr, gpr_wdata, pending_cnt, err
   );
endinterface

// File: rtl/gpr_wb_scheduler.sv
// Writeback scheduler + pending-write scoreboard for the GPR file.
// Two requesters share the single write port under round-robin; the
// busy vector tracks reserved destinations for RAW/WAW stalls in decode.
module gpr_wb_scheduler #(
   parameter int XLEN = 32,
   parameter int RAW  = 5,
   parameter int NREG = 32
) (
   input logic               clk,
   input logic               rst,
   gpr_wb_scheduler_if.slave bus
);
   typedef struct packed {
      logic [RAW-1:0]  addr;
      logic [XLEN-1:0] data;
   } wb_req_t;

   logic [NREG-1:0] busy, busy_nxt;
   logic [RAW:0]    cnt, cnt_nxt;
   logic            last_grant;   // 1: requester 1 was granted most recently
   logic            err_q;
   logic            wena_q;
   logic [RAW-1:0]  waddr_q;
   logic [XLEN-1:0] wdata_q;

   wb_req_t [1:0] req;
   wb_req_t       sel;
   logic [1:0]    vld, grant;
   logic          xfer, issue_ok, set_en, clr_en;

   assign vld    = {bus.wb1_valid, bus.wb0_valid};
   assign req[0] = {bus.wb0_addr, bus.wb0_data};
   assign req[1] = {bus.wb1_addr, bus.wb1_data};

   // Round-robin pick: on contention the requester not granted last time wins.
   always_comb begin
      grant = 2'b00;
      if (!rst) begin
         if (vld[0] && (!vld[1] || last_grant)) grant[0] = 1'b1;
         else if (vld[1])                       grant[1] = 1'b1;
      end
   end

   assign xfer     = |grant;
   assign sel      = grant[1] ? req[1] : req[0];
   assign issue_ok = !rst && (bus.issue_rd == '0 || !busy[bus.issue_rd]);
   assign set_en   = bus.issue_valid && issue_ok && (bus.issue_rd != '0);
   // Only clear a bit that is really set, so the count stays a true popcount
   // even after a stray write to an unreserved register.
   assign clr_en   = wena_q && busy[waddr_q] && !(set_en && bus.issue_rd == waddr_q);

   // Next scoreboard state and pending count; a set beats a clear on one register.
   always_comb begin
      busy_nxt = busy;
      if (clr_en) busy_nxt[waddr_q]      = 1'b0;
      if (set_en) busy_nxt[bus.issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
      cnt_nxt = cnt;
      if (set_en && !clr_en)      cnt_nxt = cnt + 1'b1;
      else if (clr_en && !set_en) cnt_nxt = cnt - 1'b1;
   end

   // State update: scoreboard, arbiter history, write-port register, sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy       <= '0;
         cnt        <= '0;
         last_grant <= 1'b1;
         err_q      <= 1'b0;
         wena_q     <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
      end else begin
         busy <= busy_nxt;
         cnt  <= cnt_nxt;
         if (xfer) begin
            last_grant <= grant[1];
            wena_q     <= (sel.addr != '0);
            waddr_q    <= sel.addr;
            wdata_q    <= sel.data;
         end else begin
            wena_q <= 1'b0;
         end
         if (xfer && sel.addr != '0 && !busy[sel.addr]) err_q <= 1'b1;
      end
   end

   assign bus.issue_ready = issue_ok;
   assign bus.busy1       = busy[bus.rs1];
   assign bus.busy2       = busy[bus.rs2];
   assign bus.wb0_ready   = grant[0];
   assign bus.wb1_ready   = grant[1];
   assign bus.gpr_wena    = wena_q;
   assign bus.gpr_waddr   = waddr_q;
   assign bus.gpr_wdata   = wdata_q;
   assign bus.pending_cnt = cnt;
   assign bus.err         = err_q;
endmodule

// File: tb/tb_gpr_wb_scheduler.sv
// Bench for gpr_wb_scheduler: directed scenarios followed by random traffic,
// checked against a cycle-level reference model. Register-file writes are
// predicted into a queue and matched by an independent monitor.
module tb_gpr_wb_scheduler;
   localparam int XLEN = 32;
   localparam int RAW  = 5;
   localparam int NREG = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gpr_wb_scheduler_if #(.XLEN(XLEN), .RAW(RAW)) bus();
   gpr_wb_scheduler #(.XLEN(XLEN), .RAW(RAW), .NREG(NREG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      int              a;
      logic [XLEN-1:0] d;
      int              due;
   } wr_t;

   // reference model state
   bit  mbusy [NREG];
   bit  merr;
   int  mlast;        // index of requester granted most recently
   int  mclr;         // register whose commit ends this cycle, -1 if none
   wr_t exp_q [$];
   bit  eg0, eg1;     // model grants for the cycle just stepped
   bit  mon_en = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      merr  = 1'b0;
      mlast = 1;
      mclr  = -1;
   endtask

   // One clock: compare combinational outputs mid-cycle, then advance the model.
   task automatic step();
      int              pc, xa, nclr;
      logic [XLEN-1:0] xd;
      bit              eir;
      @(negedge clk);
      eg0 = !rst && bus.wb0_valid && (!bus.wb1_valid || mlast == 1);
      eg1 = !rst && bus.wb1_valid && !eg0;
      eir = !rst && (bus.issue_rd == 0 || !mbusy[bus.issue_rd]);
      pc  = 0;
      foreach (mbusy[i]) pc += int'(mbusy[i]);
      chk("wb0_ready",   bus.wb0_ready,   eg0);
      chk("wb1_ready",   bus.wb1_ready,   eg1);
      chk("issue_ready", bus.issue_ready, eir);
      chk("busy1",       bus.busy1,       mbusy[bus.rs1]);
      chk("busy2",       bus.busy2,       mbusy[bus.rs2]);
      chk("pending_cnt", bus.pending_cnt, pc);
      chk("err",         bus.err,         merr);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         xa = -1; nclr = -1; xd = '0;
         if (eg0)      begin xa = int'(bus.wb0_addr); xd = bus.wb0_data; mlast = 0; end
         else if (eg1) begin xa = int'(bus.wb1_addr); xd = bus.wb1_data; mlast = 1; end
         if (xa > 0) begin
            wr_t w;
            w.a = xa; w.d = xd; w.due = cyc + 1;
            exp_q.push_back(w);
            if (!mbusy[xa]) merr = 1'b1;
            nclr = xa;
         end
         if (mclr > 0) mbusy[mclr] = 1'b0;
         if (bus.issue_valid && eir && bus.issue_rd != 0) mbusy[bus.issue_rd] = 1'b1;
         mclr = nclr;
      end
      cyc++;
      #1;
   endtask

   // Write-port monitor: every cycle either a predicted write is due or the port is idle.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
               e = exp_q.pop_front();
               chk("gpr_wena",  bus.gpr_wena,  1'b1);
               chk("gpr_waddr", bus.gpr_waddr, e.a);
               chk("gpr_wdata", bus.gpr_wdata, e.d);
            end else begin
               chk("gpr_wena_idle", bus.gpr_wena, 1'b0);
            end
         end
      end
   end

   function automatic logic [RAW-1:0] pick_reg();
      if ($urandom_range(0, 9) < 7) return RAW'($urandom_range(0, 7));
      return RAW'($urandom_range(0, NREG - 1));
   endfunction

   initial begin
      int i0, i1;
      rst = 1'b1;
      bus.issue_valid = 0; bus.issue_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
      bus.wb0_valid = 0; bus.wb0_addr = 0; bus.wb0_data = 0;
      bus.wb1_valid = 0; bus.wb1_addr = 0; bus.wb1_data = 0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      mon_en = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("rst_wena",  bus.gpr_wena,    1'b0);
      chk("rst_waddr", bus.gpr_waddr,   5'd0);
      chk("rst_wdata", bus.gpr_wdata,   32'd0);
      chk("rst_cnt",   bus.pending_cnt, 6'd0);
      chk("rst_err",   bus.err,         1'b0);

      // contention from reset: requester 0 first, x3 then x4
      bus.issue_valid = 1; bus.issue_rd = 3; step();
      bus.issue_rd = 4; step();
      bus.issue_valid = 0;
      bus.wb0_valid = 1; bus.wb0_addr = 3; bus.wb0_data = 32'h3333_0003;
      bus.wb1_valid = 1; bus.wb1_addr = 4; bus.wb1_data = 32'h4444_0004;
      #1;
      chk("t2_first_r0", bus.wb0_ready, 1'b1);
      chk("t2_first_r1", bus.wb1_ready, 1'b0);
      step();
      bus.wb0_valid = 0;
      #1;
      chk("t2_second_r1", bus.wb1_ready, 1'b1);
      chk("t2_waddr3",    bus.gpr_waddr, 5'd3);
      step();
      bus.wb1_valid = 0;
      chk("t2_waddr4", bus.gpr_waddr, 5'd4);
      chk("t2_wena4",  bus.gpr_wena,  1'b1);
      step(); step();

      // sustained contention: strict alternation
      for (int k = 0; k < 6; k++) begin
         bus.issue_valid = 1; bus.issue_rd = RAW'(10 + k); step();
      end
      bus.issue_valid = 0;
      i0 = 0; i1 = 0;
      bus.wb0_valid = 1; bus.wb1_valid = 1;
      for (int k = 0; k < 6; k++) begin
         bus.wb0_addr = RAW'(10 + 2 * i0); bus.wb0_data = 32'hA000_0000 + 32'(i0);
         bus.wb1_addr = RAW'(11 + 2 * i1); bus.wb1_data = 32'hB000_0000 + 32'(i1);
         #1;
         chk("t3_alt_r0", bus.wb0_ready, (k % 2) == 0);
         chk("t3_alt_r1", bus.wb1_ready, (k % 2) == 1);
         step();
         if (k % 2 == 0) i0++; else i1++;
      end
      bus.wb0_valid = 0; bus.wb1_valid = 0;
      repeat (3) step();

      // basic issue -> writeback -> clear
      bus.issue_valid = 1; bus.issue_rd = 5; bus.rs1 = 5; step();
      bus.issue_valid = 0;
      chk("t1_busy1_set", bus.busy1, 1'b1);
      chk("t1_cnt1",      bus.pending_cnt, 6'd1);
      bus.wb0_valid = 1; bus.wb0_addr = 5; bus.wb0_data = 32'hDEADBEEF;
      step();
      bus.wb0_valid = 0;
      chk("t1_wena",      bus.gpr_wena,  1'b1);
      chk("t1_waddr",     bus.gpr_waddr, 5'd5);
      chk("t1_wdata",     bus.gpr_wdata, 32'hDEADBEEF);
      chk("t1_busy1_hold", bus.busy1,    1'b1);
      step();
      chk("t1_busy1_clr", bus.busy1,       1'b0);
      chk("t1_cnt0",      bus.pending_cnt, 6'd0);
      chk("t1_err",       bus.err,         1'b0);

      // WAW stall on x7, and set/clear in one cycle
      bus.issue_valid = 1; bus.issue_rd = 7; step();
      #1;
      chk("t4_blocked", bus.issue_ready, 1'b0);
      bus.wb0_valid = 1; bus.wb0_addr = 7; bus.wb0_data = 32'h7777_0007;
      step();
      bus.wb0_valid = 0;
      #1;
      chk("t4_blocked_commit", bus.issue_ready, 1'b0);
      step();
      chk("t4_open", bus.issue_ready, 1'b1);
      step();
      bus.issue_valid = 0;
      chk("t4_cnt_re", bus.pending_cnt, 6'd1);
      bus.wb1_valid = 1; bus.wb1_addr = 7; bus.wb1_data = 32'h7777_0077;
      step();
      bus.wb1_valid = 0;
      bus.issue_valid = 1; bus.issue_rd = 8; bus.rs2 = 8;
      step();
      bus.issue_valid = 0;
      chk("t4_cnt_same", bus.pending_cnt, 6'd1);
      chk("t4_busy8",    bus.busy2,       1'b1);
      bus.wb0_valid = 1; bus.wb0_addr = 8; bus.wb0_data = 32'h8888_0008;
      step();
      bus.wb0_valid = 0;
      step(); step();

      // x0 write (no port write, no error), then stray x9 write (sticky error)
      bus.wb1_valid = 1; bus.wb1_addr = 0; bus.wb1_data = 32'h0BAD_0000;
      #1;
      chk("t5_x0_ready", bus.wb1_ready, 1'b1);
      step();
      bus.wb1_valid = 0;
      chk("t5_x0_wena", bus.gpr_wena, 1'b0);
      chk("t5_x0_err",  bus.err,      1'b0);
      bus.wb0_valid = 1; bus.wb0_addr = 9; bus.wb0_data = 32'h9999_0009;
      step();
      bus.wb0_valid = 0;
      chk("t5_x9_wena",  bus.gpr_wena,  1'b1);
      chk("t5_x9_waddr", bus.gpr_waddr, 5'd9);
      step();
      chk("t5_err_set", bus.err, 1'b1);
      step(); step();
      chk("t5_err_sticky", bus.err, 1'b1);

      // reset mid-operation
      for (int k = 1; k <= 3; k++) begin
         bus.issue_valid = 1; bus.issue_rd = RAW'(k); step();
      end
      bus.issue_rd = 4; bus.rs1 = 1; bus.rs2 = 2;
      bus.wb0_valid = 1; bus.wb0_addr = 1; bus.wb0_data = 32'h1111_0001;
      bus.wb1_valid = 1; bus.wb1_addr = 2; bus.wb1_data = 32'h2222_0002;
      rst = 1'b1;
      #1;
      chk("t6_rst_r0", bus.wb0_ready,   1'b0);
      chk("t6_rst_r1", bus.wb1_ready,   1'b0);
      chk("t6_rst_ir", bus.issue_ready, 1'b0);
      step(); step();
      rst = 1'b0; bus.issue_valid = 0;
      #1;
      chk("t6_cnt",   bus.pending_cnt, 6'd0);
      chk("t6_err",   bus.err,         1'b0);
      chk("t6_wena",  bus.gpr_wena,    1'b0);
      chk("t6_busy1", bus.busy1,       1'b0);
      chk("t6_busy2", bus.busy2,       1'b0);
      chk("t6_first_r0", bus.wb0_ready, 1'b1);
      chk("t6_first_r1", bus.wb1_ready, 1'b0);
      step();
      bus.wb0_valid = 0;
      step();
      bus.wb1_valid = 0;
      step(); step();

      // random traffic; requesters hold until granted
      for (int n = 0; n < 800; n++) begin
         rst = ($urandom_range(0, 63) == 0);
         if (!bus.wb0_valid || eg0) begin
            bus.wb0_valid = $urandom_range(0, 1) == 1;
            bus.wb0_addr  = pick_reg();
            bus.wb0_data  = $urandom;
         end
         if (!bus.wb1_valid || eg1) begin
            bus.wb1_valid = $urandom_range(0, 1) == 1;
            bus.wb1_addr  = pick_reg();
            bus.wb1_data  = $urandom;
         end
         bus.issue_valid = $urandom_range(0, 1) == 1;
         bus.issue_rd    = pick_reg();
         bus.rs1         = pick_reg();
         bus.rs2         = pick_reg();
         step();
      end
      rst = 1'b0;
      bus.wb0_valid = 0; bus.wb1_valid = 0; bus.issue_valid = 0;
      repeat (4) step();
      chk("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
